sw_traceback: RTL and testbench

Traceback engine for the Smith-Waterman score array: the reader-side counterpart of the per-cell scoring logic. Given the coordinates of the winning cell, it walks the stored 2-bit direction pointers (the choice each cell made among diagonal, up and left) back toward the origin. It emits one alignment operation per step over a ready/valid stream. It sits between the pointer RAM written by the systolic cell array and the alignment-report packer.

---
 rtl/sw_traceback.sv | 187 ++++++++++++++++++
 tb/tb_sw_traceback.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_traceback.sv
// ---------------------------------------------------------------------------
// sw_traceback
//
// Traceback engine for the Smith-Waterman score array. Starting from the
// winning cell it reads the stored 2-bit direction pointers out of the
// pointer RAM and walks back toward the origin. Each step produces one
// alignment operation on a ready/valid stream.
//
// Optional feature macro: SW_TB_ABORT_EN
//   defined   : adds input 'abort'. In any non-IDLE state it returns the
//               engine to IDLE on the next edge, with no done pulse.
//               path_len keeps the count accepted so far.
//   undefined : no abort port. A traceback always runs to DONE.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin traceback (sampled only in IDLE)
//   start_row, start_col  coordinates of the winning cell (saturated)
//   abort                 (SW_TB_ABORT_EN only) cancel the traceback
//   rd_en, rd_row, rd_col pointer RAM read strobe and address (FETCH only)
//   rd_data               pointer 00 stop / 01 diag / 10 up / 11 left,
//                         valid the cycle after rd_en
//   op_valid, op_ready    output stream handshake
//   op                    01 diag, 10 up (gap in subject), 11 left (gap in query)
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse at the end of the traceback
//   path_len              ops emitted; valid with done, held until next start
//   dbg_state             current FSM state, for observation only
//
// Handshake: op is transferred on every rising edge where op_valid and
// op_ready are both high. Once op_valid is raised, op stays stable and
// op_valid stays high until that transfer. Only reset or abort can end
// it early.
// ---------------------------------------------------------------------------
module sw_traceback #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS),
  parameter int LW   = $clog2(ROWS + COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [RW-1:0] start_row,
  input  logic [CW-1:0] start_col,
`ifdef SW_TB_ABORT_EN
  input  logic          abort,
`endif
  output logic          rd_en,
  output logic [RW-1:0] rd_row,
  output logic [CW-1:0] rd_col,
  input  logic [1:0]    rd_data,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [1:0]    op,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] path_len,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] PTR_STOP = 2'b00;
  localparam logic [1:0] PTR_DIAG = 2'b01;
  localparam logic [1:0] PTR_UP   = 2'b10;
  localparam logic [1:0] PTR_LEFT = 2'b11;

  // Limits held one bit wider than the index so the saturation compare
  // stays meaningful even when ROWS/COLS is a power of two.
  localparam logic [RW:0]   ROWS_W   = (RW + 1)'(ROWS);
  localparam logic [CW:0]   COLS_W   = (CW + 1)'(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    op_q, op_d;
  logic [LW-1:0] len_q, len_d;
  logic          abort_w;
  logic          move_row, move_col, leaves;

`ifdef SW_TB_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // A diagonal move changes both coordinates. Up changes only the row.
  // Left changes only the column. The path ends when a move would step
  // below index 0. The coordinates are left untouched in that case, so
  // they never wrap.
  always_comb begin
    move_row = (op_q == PTR_DIAG) || (op_q == PTR_UP);
    move_col = (op_q == PTR_DIAG) || (op_q == PTR_LEFT);
    leaves   = (move_row && (row_q == '0)) || (move_col && (col_q == '0));
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    op_d    = op_q;
    len_d   = len_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_d   = ({1'b0, start_row} >= ROWS_W) ? ROW_LAST : start_row;
          col_d   = ({1'b0, start_col} >= COLS_W) ? COL_LAST : start_col;
          len_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rd_data == PTR_STOP) begin
          state_d = ST_DONE;
        end else begin
          op_d    = rd_data;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (op_ready) begin
          len_d = len_q + LW'(1);
          if (leaves) begin
            state_d = ST_DONE;
          end else begin
            if (move_row) row_d = row_q - RW'(1);
            if (move_col) col_d = col_q - CW'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including an accept in the same cycle.
    // That op therefore does not count.
    if (abort_w && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      row_d   = row_q;
      col_d   = col_q;
      op_d    = op_q;
      len_d   = len_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      op_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      op_q    <= op_d;
      len_q   <= len_d;
    end
  end

  // All outputs decode from registered state. Reset therefore clears
  // every one of them at the same instant.
  assign rd_en     = (state_q == ST_FETCH);
  assign rd_row    = rd_en ? row_q : '0;
  assign rd_col    = rd_en ? col_q : '0;
  assign op_valid  = (state_q == ST_EMIT);
  assign op        = op_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign path_len  = len_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sw_traceback.sv
module tb_sw_traceback;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int RW   = 3;
  localparam int CW   = 3;
  localparam int LW   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [RW-1:0] start_row = '0;
  logic [CW-1:0] start_col = '0;
`ifdef SW_TB_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic          rd_en;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [1:0]    rd_data = 2'b00;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [1:0]    op;
  logic          busy;
  logic          done;
  logic [LW-1:0] path_len;
  logic [2:0]    dbg_state;

  sw_traceback #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .start_row(start_row), .start_col(start_col),
`ifdef SW_TB_ABORT_EN
    .abort(abort),
`endif
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .busy(busy), .done(done), .path_len(path_len), .dbg_state(dbg_state)
  );

  // Pointer RAM: one-cycle read latency
  logic [1:0] mem [ROWS][COLS];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_row][rd_col];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [RW+CW-1:0] exp_rd_q[$];
  logic [1:0]       exp_op_q[$];
  logic [LW-1:0]    exp_len_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int  n_acc = 0, n_rd = 0, n_done = 0;
  int  first_rd_cyc, first_ov_cyc, last_acc_cyc, done_cyc;
  bit  seen_rd, seen_ov;
  bit  hold_prev = 0;
  bit  no_hold_chk = 0;
  logic [1:0] hold_op;
  int  rdy_mode = 0;   // 0 always ready, 1 random, 2 four-cycle backpressure, 3 manual
  int  bp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  task automatic flush_exp();
    exp_rd_q.delete();
    exp_op_q.delete();
    exp_len_q.delete();
  endtask

  // Reference model: walk the pointer table from the start cell.
  task automatic model_push(input int r0, input int c0);
    int r, c, n;
    bit go, dr, dc;
    logic [1:0] p;
    r = (r0 >= ROWS) ? ROWS - 1 : r0;
    c = (c0 >= COLS) ? COLS - 1 : c0;
    n = 0;
    go = 1;
    while (go) begin
      exp_rd_q.push_back({RW'(r), CW'(c)});
      p = mem[r][c];
      if (p == 2'b00) begin
        go = 0;
      end else begin
        exp_op_q.push_back(p);
        n++;
        dr = (p != 2'b11);
        dc = (p != 2'b10);
        if ((dr && r == 0) || (dc && c == 0)) go = 0;
        else begin
          if (dr) r--;
          if (dc) c--;
        end
      end
    end
    exp_len_q.push_back(LW'(n));
  endtask

  // ---------------- monitor ----------------
  logic [RW+CW-1:0] m_rd;
  logic [1:0]       m_op;
  logic [LW-1:0]    m_len;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (rd_en) begin
        n_rd++;
        if (!seen_rd) begin seen_rd = 1; first_rd_cyc = cyc; end
        if (exp_rd_q.size() == 0) fail_evt("rd_extra");
        else begin m_rd = exp_rd_q.pop_front(); check("rd_addr", {rd_row, rd_col}, m_rd); end
      end
      if (op_valid && !seen_ov) begin seen_ov = 1; first_ov_cyc = cyc; end
      if (hold_prev && !no_hold_chk) begin
        check("op_hold_valid", op_valid, 1);
        check("op_hold_value", op, hold_op);
      end
      hold_prev = op_valid && !op_ready;
      hold_op   = op;
      if (op_valid && op_ready) begin
        n_acc++;
        last_acc_cyc = cyc;
        if (exp_op_q.size() == 0) fail_evt("op_extra");
        else begin m_op = exp_op_q.pop_front(); check("op", op, m_op); end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (exp_len_q.size() == 0) fail_evt("done_extra");
        else begin m_len = exp_len_q.pop_front(); check("path_len", path_len, m_len); end
      end
    end
  end

  // ---------------- op_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: op_ready = 1'b1;
        1: op_ready = 1'($urandom_range(0, 1));
        2: begin
          if (op_valid && bp_cnt < 4) begin op_ready = 1'b0; bp_cnt++; end
          else begin op_ready = 1'b1; if (!op_valid) bp_cnt = 0; end
        end
        default: ;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int r, input int c);
    @(posedge clk);
    #1;
    seen_rd = 0;
    seen_ov = 0;
    n_acc = 0;
    n_rd = 0;
    start = 1'b1;
    start_row = RW'(r);
    start_col = CW'(c);
    model_push(r, c);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  // start pulse while busy: must be ignored, so nothing is expected
  task automatic poke_start(input int r, input int c);
    start = 1'b1;
    start_row = RW'(r);
    start_col = CW'(c);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int k, base;
    base = n_done;
    k = 0;
    while (n_done == base && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    if (n_done == base) fail_evt("done_timeout");
    #1;
    check("busy_fall", busy, 0);
    check("ops_left", exp_op_q.size(), 0);
    check("reads_left", exp_rd_q.size(), 0);
  endtask

  task automatic fill_all(input logic [1:0] p);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mem[r][c] = p;
  endtask

  task automatic fill_random();
    int x;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        x = $urandom_range(0, 9);
        mem[r][c] = (x == 0) ? 2'b00 : 2'(1 + (x % 3));
      end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    fill_all(2'b01);
    #3;
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_row", rd_row, 0);
    check("rst_rd_col", rd_col, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_op", op, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_path_len", path_len, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // diagonal run
    rdy_mode = 0;
    fill_all(2'b01);
    do_start(7, 7);
    wait_done(200);
    check("diag_span", last_acc_cyc - first_rd_cyc, 23);
    check("diag_first_op", first_ov_cyc - first_rd_cyc, 2);
    check("diag_done_lat", done_cyc - last_acc_cyc, 1);
    check("diag_accepts", n_acc, 8);

    // immediate stop
    mem[3][4] = 2'b00;
    do_start(3, 4);
    wait_done(50);
    check("stop_done_lat", done_cyc - first_rd_cyc, 2);
    check("stop_no_op", seen_ov, 0);
    check("stop_reads", n_rd, 1);

    // mixed path with backpressure
    fill_random();
    mem[5][5] = 2'b11;
    mem[5][4] = 2'b10;
    mem[4][4] = 2'b01;
    mem[3][3] = 2'b00;
    rdy_mode = 2;
    do_start(5, 5);
    wait_done(300);
    check("mixed_accepts", n_acc, 3);

    // edge exit along row 0
    rdy_mode = 0;
    fill_random();
    for (int c = 0; c < COLS; c++) mem[0][c] = 2'b11;
    do_start(0, 6);
    wait_done(200);
    check("edge_accepts", n_acc, 7);
    check("edge_reads", n_rd, 7);

    // reset during EMIT of the second op
    fill_all(2'b01);
    rdy_mode = 3;
    op_ready = 1'b1;
    do_start(5, 5);
    k = 0;
    while (n_acc < 1 && k < 100) begin @(negedge clk); #1; k++; end
    op_ready = 1'b0;
    k = 0;
    while (!op_valid && k < 100) begin @(negedge clk); k++; end
    if (!op_valid) fail_evt("rst_wait_emit");
    no_hold_chk = 1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_op_valid", op_valid, 0);
    check("mid_rst_op", op, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_path_len", path_len, 0);
    check("mid_rst_rd_en", rd_en, 0);
    flush_exp();
    @(posedge clk); #1;
    rst_n = 1'b1;
    no_hold_chk = 0;
    rdy_mode = 0;
    do_start(2, 2);
    wait_done(100);
    check("post_rst_accepts", n_acc, 3);

`ifdef SW_TB_ABORT_EN
    // abort during WAIT of the third step; a start while busy is ignored
    fill_all(2'b01);
    rdy_mode = 0;
    do_start(6, 6);
    poke_start(1, 1);
    k = 0;
    while (n_rd < 3 && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    check("abort_in_wait", dbg_state, 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", dbg_state, 0);
    check("abort_busy", busy, 0);
    check("abort_op_valid", op_valid, 0);
    check("abort_path_len", path_len, 2);
    flush_exp();
    repeat (4) @(posedge clk);
    check("abort_len_held", path_len, 2);
`endif

    // randomized traces
    for (int i = 0; i < 25; i++) begin
      fill_random();
      rdy_mode = $urandom_range(0, 2);
      do_start($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
      if (i % 2 == 1) poke_start($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
      wait_done(500);
    end

    repeat (3) @(posedge clk);
    check("final_exp_len_empty", exp_len_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
